// File: rtl/fetch_queue_pkg.sv
// Shared types and widths for the two-wide fetch queue.
// Entry layout carries branch-prediction metadata alongside pc/instr.
package fetch_queue_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PHT_ADDRESS = 9;
  localparam int unsigned FQ_DEPTH    = 16;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        instr;
    logic                   pred_taken;
    logic [XLEN-1:0]        pred_target;
    logic [PHT_ADDRESS-1:0] pht_index;
  } fq_entry_t;

  localparam int unsigned FQ_W     = $bits(fq_entry_t);
  localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned FQ_CNT_W = FQ_PTR_W + 1;

  // Number of set bits in a 2-bit slot mask.
  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: fetch side enqueue, decode side dequeue, flush.
// master = fetch/decode environment, slave = the queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic [1:0]       enq_valid;
  fq_entry_t        enq_entry0;
  fq_entry_t        enq_entry1;
  logic             enq_ready;
  logic [1:0]       deq_valid;
  fq_entry_t        deq_entry0;
  fq_entry_t        deq_entry1;
  logic [1:0]       deq_accept;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, enq_valid, enq_entry0, enq_entry1, deq_accept,
    input  enq_ready, deq_valid, deq_entry0, deq_entry1, count
  );

  modport slave (
    input  flush, enq_valid, enq_entry0, enq_entry1, deq_accept,
    output enq_ready, deq_valid, deq_entry0, deq_entry1, count
  );

endinterface

// File: rtl/fq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for fetch_queue; enq_ready and deq_valid
// are registered from the next-state occupancy.
module fq_ptr_ctrl
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [1:0]                 enq_valid,
  input  logic [1:0]                 deq_accept,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       enq_ready,
  output logic [1:0]                 deq_valid,
  output logic                       enq_fire
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    enq_fire   = enq_ready & (|enq_valid);
    n_enq      = enq_fire ? popcount2(enq_valid) : 2'd0;
    n_deq      = popcount2(deq_accept);
    count_next = count + CNT_W'(n_enq) - CNT_W'(n_deq);
  end

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      enq_ready <= 1'b1;
      deq_valid <= '0;
    end else begin
      head      <= head + PTR_W'(n_deq);
      tail      <= tail + PTR_W'(n_enq);
      count     <= count_next;
      enq_ready <= (count_next <= CNT_W'(DEPTH - 2));
      if (count_next == '0)
        deq_valid <= 2'b00;
      else if (count_next == CNT_W'(1))
        deq_valid <= 2'b01;
      else
        deq_valid <= 2'b11;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Two-wide fetch queue between predict/fetch and decode, flushed on redirect.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency pass-through when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic          CLK,
  input  logic          reset,
  fetch_queue_if.slave  fq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head1;
  logic [PTR_W-1:0] tail1;
  logic [1:0]       deq_valid_q;
  logic             enq_fire;
  logic             wr0;
  logic             wr1;

  fq_entry_t mem [DEPTH];

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .CLK        (CLK),
    .reset      (reset),
    .flush      (fq.flush),
    .enq_valid  (fq.enq_valid),
    .deq_accept (fq.deq_accept),
    .head       (head),
    .tail       (tail),
    .count      (fq.count),
    .enq_ready  (fq.enq_ready),
    .deq_valid  (deq_valid_q),
    .enq_fire   (enq_fire)
  );

  always_comb begin
    head1 = head + PTR_W'(1);
    tail1 = tail + PTR_W'(1);
    wr0   = enq_fire & ~fq.flush & ~reset & fq.enq_valid[0];
    wr1   = enq_fire & ~fq.flush & ~reset & fq.enq_valid[1];
  end

  always_ff @(posedge CLK) begin
    if (wr0) mem[tail]  <= fq.enq_entry0;
    if (wr1) mem[tail1] <= fq.enq_entry1;
  end

  // Bypassed entries are still written; head advancing past the accepted
  // ones gives the same visible state as skipping their writes.
  always_comb begin
    fq.deq_valid  = deq_valid_q;
    fq.deq_entry0 = mem[head];
    fq.deq_entry1 = mem[head1];
`ifdef FETCH_QUEUE_BYPASS_EN
    if ((fq.count == '0) && enq_fire) begin
      fq.deq_valid  = fq.enq_valid;
      fq.deq_entry0 = fq.enq_entry0;
      fq.deq_entry1 = fq.enq_entry1;
    end
`endif
  end

  a_enq_valid_legal: assert property (@(posedge CLK) disable iff (reset)
    fq.enq_valid != 2'b10);
  a_deq_accept_prefix: assert property (@(posedge CLK) disable iff (reset)
    fq.deq_accept != 2'b10);
  a_deq_accept_subset: assert property (@(posedge CLK) disable iff (reset)
    (fq.deq_accept & ~fq.deq_valid) == 2'b00);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares whatever decode accepts.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  fq_entry_t sb[$];
  logic [31:0] pc;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .fq    (fq)
  );

  always #5 CLK = ~CLK;

  function automatic fq_entry_t mk(input logic [31:0] p);
    fq_entry_t e;
    e.pc          = p;
    e.instr       = p ^ 32'h1357_9BDF;
    e.pred_taken  = p[3];
    e.pred_target = p + 32'h40;
    e.pht_index   = p[10:2];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted slot must match the oldest expected entry.
  always @(negedge CLK) begin : monitor
    fq_entry_t e;
    fq_entry_t got;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (fq.deq_accept[i]) begin
          got = (i == 0) ? fq.deq_entry0 : fq.deq_entry1;
          chk("deq_valid_on_accept", 64'(fq.deq_valid[i]), 64'd1);
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow actual_pc=0x%0h required=none", got.pc);
          end else begin
            e = sb.pop_front();
            if (got !== e) begin
              failures++;
              $display("FAIL deq_entry slot%0d actual_pc=0x%0h required_pc=0x%0h", i, got.pc, e.pc);
            end
          end
        end
      end
    end
  end

  task automatic cycle(input logic [1:0] ev, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic [1:0] acc, input logic fl);
    fq.enq_valid  = ev;
    fq.enq_entry0 = mk(pc0);
    fq.enq_entry1 = mk(pc1);
    fq.deq_accept = acc;
    fq.flush      = fl;
    if (fq.enq_ready && ev != 2'b00 && !fl && !reset) begin
      sb.push_back(mk(pc0));
      if (ev[1]) sb.push_back(mk(pc1));
    end
    @(posedge CLK);
    #1;
    if (fl || reset) sb.delete();
    fq.enq_valid  = '0;
    fq.deq_accept = '0;
    fq.flush      = 1'b0;
  endtask

  initial begin
    fq.flush      = 1'b0;
    fq.enq_valid  = '0;
    fq.enq_entry0 = '0;
    fq.enq_entry1 = '0;
    fq.deq_accept = '0;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    chk("reset_count", 64'(fq.count), 64'd0);
    chk("reset_deq_valid", 64'(fq.deq_valid), 64'd0);
    chk("reset_enq_ready", 64'(fq.enq_ready), 64'd1);

    // 1: first pair visible one cycle later
    cycle(2'b11, 32'h100, 32'h104, 2'b00, 1'b0);
    pc = 32'h108;
    chk("t1_count", 64'(fq.count), 64'd2);
    chk("t1_deq_valid", 64'(fq.deq_valid), 64'b11);
    chk("t1_deq0_pc", 64'(fq.deq_entry0.pc), 64'h100);
    chk("t1_deq1_pc", 64'(fq.deq_entry1.pc), 64'h104);

    // 2: fill to DEPTH-1, then drain one while the producer holds its pair
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, pc, pc + 32'd4, 2'b00, 1'b0);
      pc += 32'd8;
    end
    chk("t2_count14", 64'(fq.count), 64'd14);
    chk("t2_ready_at14", 64'(fq.enq_ready), 64'd1);
    cycle(2'b01, pc, 32'h0, 2'b00, 1'b0);
    pc += 32'd4;
    chk("t2_count15", 64'(fq.count), 64'd15);
    chk("t2_full_ready", 64'(fq.enq_ready), 64'd0);
    cycle(2'b11, pc, pc + 32'd4, 2'b01, 1'b0);
    chk("t2_count_after_deq", 64'(fq.count), 64'd14);
    chk("t2_ready_after_deq", 64'(fq.enq_ready), 64'd1);

    // 3: steady state 2-in/2-out across pointer wrap
    for (int i = 0; i < 3 * int'(DEPTH); i++) begin
      cycle(2'b11, pc, pc + 32'd4, 2'b11, 1'b0);
      pc += 32'd8;
      chk("t3_count_stable", 64'(fq.count), 64'd14);
    end

    // 4: drain to 5, then flush with enq and deq requested
    for (int i = 0; i < 4; i++) cycle(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    cycle(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    chk("t4_count5", 64'(fq.count), 64'd5);
    cycle(2'b11, 32'hDEAD0, 32'hDEAD4, 2'b11, 1'b1);
    chk("t4_flush_count", 64'(fq.count), 64'd0);
    chk("t4_flush_deq_valid", 64'(fq.deq_valid), 64'd0);
    chk("t4_flush_ready", 64'(fq.enq_ready), 64'd1);

    // 5: count=1, dequeue one while enqueueing two
    cycle(2'b01, 32'h300, 32'h0, 2'b00, 1'b0);
    chk("t5_count1", 64'(fq.count), 64'd1);
    chk("t5_deq_valid01", 64'(fq.deq_valid), 64'b01);
    cycle(2'b11, 32'h310, 32'h314, 2'b01, 1'b0);
    chk("t5_count2", 64'(fq.count), 64'd2);
    chk("t5_deq0_pc", 64'(fq.deq_entry0.pc), 64'h310);
    chk("t5_deq_valid11", 64'(fq.deq_valid), 64'b11);

    // reset mid-operation behaves as flush
    cycle(2'b11, 32'h320, 32'h324, 2'b00, 1'b0);
    chk("rst_pre_count", 64'(fq.count), 64'd4);
    reset = 1'b1;
    cycle(2'b11, 32'h330, 32'h334, 2'b01, 1'b0);
    reset = 1'b0;
    chk("rst_count", 64'(fq.count), 64'd0);
    chk("rst_deq_valid", 64'(fq.deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(fq.enq_ready), 64'd1);
    cycle(2'b11, 32'h340, 32'h344, 2'b00, 1'b0);
    chk("rst_post_count", 64'(fq.count), 64'd2);
    chk("rst_post_deq0_pc", 64'(fq.deq_entry0.pc), 64'h340);
    cycle(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    chk("drain_count", 64'(fq.count), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // 6: bypass when empty, decode takes the older entry immediately
    fq.enq_valid  = 2'b11;
    fq.enq_entry0 = mk(32'h200);
    fq.enq_entry1 = mk(32'h204);
    sb.push_back(mk(32'h200));
    sb.push_back(mk(32'h204));
    #1;
    chk("t6_bypass_valid", 64'(fq.deq_valid), 64'b11);
    chk("t6_bypass_deq0_pc", 64'(fq.deq_entry0.pc), 64'h200);
    fq.deq_accept = 2'b01;
    @(posedge CLK);
    #1;
    fq.enq_valid  = '0;
    fq.deq_accept = '0;
    chk("t6_count1", 64'(fq.count), 64'd1);
    chk("t6_deq0_pc", 64'(fq.deq_entry0.pc), 64'h204);
    cycle(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    chk("t6_drain_count", 64'(fq.count), 64'd0);
`endif

    @(posedge CLK);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
